// File: rtl/p_cache_ctrl_if.sv
// Fetch-side and SDRAM-side signals of the program-cache controller.
// mem_req is held until a one-cycle mem_ack; mem_valid qualifies each burst word; wr_en qualifies wr_addr/wr_data.
interface p_cache_ctrl_if #(
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 3
);
    localparam int AW = INDEX_BITS + OFFSET_BITS;

    logic [15:0]   A;
    logic          flush;
    logic          p_cache_miss;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          mem_req;
    logic [15:0]   mem_addr;
    logic          mem_ack;
    logic          mem_valid;
    logic [15:0]   mem_data;
    logic [2:0]    state_dbg;

    modport slave (
        input  A, flush, mem_ack, mem_valid, mem_data,
        output p_cache_miss, rd_addr, wr_en, wr_addr, wr_data, mem_req, mem_addr, state_dbg
    );

    modport master (
        output A, flush, mem_ack, mem_valid, mem_data,
        input  p_cache_miss, rd_addr, wr_en, wr_addr, wr_data, mem_req, mem_addr, state_dbg
    );
endinterface

// File: rtl/p_cache_ctrl.sv
// Direct-mapped program-cache controller: tag/valid lookup, SDRAM burst line fill
// into the external instruction RAM, and full invalidate after reset or on flush.
module p_cache_ctrl #(
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 3
) (
    input  logic           clk,
    input  logic           RST,
    p_cache_ctrl_if.slave  bus
);
    localparam int TW    = 16 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES = 1 << INDEX_BITS;
    localparam int AW    = INDEX_BITS + OFFSET_BITS;

    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

    state_t                 state_q, state_d;
    // Word offset is irrelevant to the lookup, so only the line address is kept.
    logic [15:OFFSET_BITS]  addr_q, addr_d;
    logic [INDEX_BITS-1:0]  flush_cnt_q, flush_cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [TW-1:0]          miss_tag_q, miss_tag_d;
    logic [INDEX_BITS-1:0]  miss_idx_q, miss_idx_d;
    logic [OFFSET_BITS-1:0] word_cnt_q, word_cnt_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TW-1:0]          tag_arr_q [LINES];
    logic [TW-1:0]          tag_arr_d [LINES];

    logic [INDEX_BITS-1:0]  idx;
    logic [TW-1:0]          tag;
    logic                   hit;
    logic                   flush_req;

    assign idx       = addr_q[AW-1:OFFSET_BITS];
    assign tag       = addr_q[15:16-TW];
    assign hit       = valid_q[idx] && (tag_arr_q[idx] == tag);
    assign flush_req = bus.flush || flush_pend_q;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) state_q <= S_FLUSH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FLUSH: if (flush_cnt_q == '1) state_d = S_IDLE;
            S_IDLE: begin
                if (flush_req) state_d = S_FLUSH;
                else if (!hit) state_d = S_REQ;
            end
            S_REQ:   if (bus.mem_ack) state_d = S_FILL;
            S_FILL:  if (bus.mem_valid && word_cnt_q == '1) state_d = S_DONE;
            S_DONE:  state_d = flush_req ? S_FLUSH : S_IDLE;
            default: state_d = S_FLUSH;
        endcase
    end

    always_comb begin
        bus.p_cache_miss = 1'b1;
        bus.mem_req      = 1'b0;
        bus.wr_en        = 1'b0;
        bus.mem_addr     = '0;
        case (state_q)
            S_IDLE: bus.p_cache_miss = !hit || flush_req;
            S_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {miss_tag_q, miss_idx_q, {OFFSET_BITS{1'b0}}};
            end
            S_FILL:  bus.wr_en = bus.mem_valid;
            default: ;
        endcase
        bus.wr_addr   = {miss_idx_q, word_cnt_q};
        bus.wr_data   = bus.mem_data;
        bus.rd_addr   = bus.A[AW-1:0];
        bus.state_dbg = state_q;
    end

    always_comb begin
        addr_d       = bus.A[15:OFFSET_BITS];
        flush_cnt_d  = flush_cnt_q;
        flush_pend_d = flush_pend_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        word_cnt_d   = word_cnt_q;
        valid_d      = valid_q;
        tag_arr_d    = tag_arr_q;

        if (state_q == S_FLUSH) begin
            valid_d[flush_cnt_q] = 1'b0;
            flush_cnt_d          = flush_cnt_q + INDEX_BITS'(1);
        end
        if (bus.flush && state_q != S_IDLE) flush_pend_d = 1'b1;
        // Entry into the sweep consumes the pending request and restarts the line counter.
        if (state_d == S_FLUSH && state_q != S_FLUSH) begin
            flush_pend_d = 1'b0;
            flush_cnt_d  = '0;
        end
        if (state_q == S_IDLE && !flush_req && !hit) begin
            miss_tag_d   = tag;
            miss_idx_d   = idx;
            valid_d[idx] = 1'b0;
        end
        if (state_q == S_REQ && bus.mem_ack) word_cnt_d = '0;
        if (state_q == S_FILL && bus.mem_valid) begin
            word_cnt_d = word_cnt_q + OFFSET_BITS'(1);
            if (word_cnt_q == '1) begin
                tag_arr_d[miss_idx_q] = miss_tag_q;
                valid_d[miss_idx_q]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            addr_q       <= '0;
            flush_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            word_cnt_q   <= '0;
            valid_q      <= '0;
            tag_arr_q    <= '{default: '0};
        end else begin
            addr_q       <= addr_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_pend_q <= flush_pend_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            word_cnt_q   <= word_cnt_d;
            valid_q      <= valid_d;
            tag_arr_q    <= tag_arr_d;
        end
    end
endmodule

// File: tb/tb_p_cache_ctrl.sv
// Directed bench for p_cache_ctrl: reset sweep, fills, eviction, gapped bursts, flush and reset mid-fill.
module tb_p_cache_ctrl;
    localparam logic [2:0] ST_FLUSH = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic clk;
    logic RST;
    int   n_cmp;
    int   n_bad;
    int   wr_cnt;
    logic [23:0] exp_q[$];

    p_cache_ctrl_if #(.INDEX_BITS(5), .OFFSET_BITS(3)) bus ();

    p_cache_ctrl #(.INDEX_BITS(5), .OFFSET_BITS(3)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for instruction-RAM writes: {wr_addr, wr_data}.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_cnt++;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("wr_addr_data", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
        end
    end

    task automatic present(input logic [15:0] a);
        @(posedge clk); #1;
        bus.A = a;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic count_flush(output int n);
        n = 0;
        while (bus.state_dbg == ST_FLUSH && bus.p_cache_miss && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // SDRAM responder for one miss; returns at the negedge of the DONE cycle,
    // or right after raising RST when rst_word is reached.
    task automatic serve(input logic [15:0] la, input int ack_wait, input int gap,
                         input logic [15:0] dbase, input int flush_word, input int rst_word,
                         output int miss_cyc, output int req_cyc);
        int req_n, k, w, guard;
        bit acked, done_seen, aborted;
        req_n = 0; k = 0; w = 0; guard = 0;
        acked = 0; done_seen = 0; aborted = 0;
        miss_cyc = 0; req_cyc = 0;
        while (!done_seen && !aborted && guard < 300) begin
            @(posedge clk); #1;
            bus.mem_ack   = 1'b0;
            bus.mem_valid = 1'b0;
            bus.flush     = 1'b0;
            if (bus.mem_req) begin
                req_n++;
                if (req_n == ack_wait + 1) begin
                    bus.mem_ack = 1'b1;
                    acked = 1;
                end
            end else if (acked && w < 8) begin
                if (k % (gap + 1) == 0) begin
                    if (w == rst_word) begin
                        RST = 1'b1;
                        aborted = 1;
                    end else begin
                        bus.mem_valid = 1'b1;
                        bus.mem_data  = dbase + 16'(w);
                        exp_q.push_back({la[7:0] | 8'(w), dbase + 16'(w)});
                        if (w == flush_word) bus.flush = 1'b1;
                        w++;
                    end
                end
                k++;
            end
            if (!aborted) begin
                @(negedge clk);
                guard++;
                if (bus.p_cache_miss) miss_cyc++;
                if (bus.mem_req) begin
                    req_cyc++;
                    check("mem_addr", 32'(bus.mem_addr), 32'(la));
                end
                if (bus.state_dbg == ST_DONE) done_seen = 1;
            end
        end
        if (!aborted) check("fill_done", 32'(done_seen), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n, mc, rc, wb;
        n_cmp = 0; n_bad = 0; wr_cnt = 0;
        RST = 1'b1;
        bus.A = 16'h0000; bus.flush = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_valid = 1'b0; bus.mem_data = 16'h0000;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_miss",     32'(bus.p_cache_miss), 32'd1);
        check("rst_mem_req",  32'(bus.mem_req),      32'd0);
        check("rst_wr_en",    32'(bus.wr_en),        32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr),     32'h0);
        check("rst_state",    32'(bus.state_dbg),    32'(ST_FLUSH));

        // Post-reset sweep, then A=0 must miss
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        count_flush(n);
        check("reset_sweep_len", n, 32);
        check("post_sweep_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        check("post_sweep_miss",  32'(bus.p_cache_miss), 32'd1);
        wb = wr_cnt;
        serve(16'h0000, 0, 0, 16'h9000, -1, -1, mc, rc);
        check("line0_miss_rest", mc, 10);
        check("line0_req_cyc",   rc, 1);
        check("line0_writes",    wr_cnt - wb, 8);
        next_cycle();
        check("line0_hit", 32'(bus.p_cache_miss), 32'd0);

        // Cold miss at 0x1234, best-case burst
        present(16'h1234);
        check("line0_still_hit", 32'(bus.p_cache_miss), 32'd0);
        check("rd_addr", 32'(bus.rd_addr), 32'h34);
        wb = wr_cnt;
        serve(16'h1230, 0, 0, 16'hA000, -1, -1, mc, rc);
        check("cold_miss_cyc", mc, 11);
        check("cold_req_cyc",  rc, 1);
        check("cold_writes",   wr_cnt - wb, 8);
        next_cycle();
        check("cold_hit",   32'(bus.p_cache_miss), 32'd0);
        check("cold_state", 32'(bus.state_dbg), 32'(ST_IDLE));

        // Conflict eviction: 0x5230 shares index 6
        present(16'h5230);
        serve(16'h5230, 0, 0, 16'hB000, -1, -1, mc, rc);
        check("conflict_miss_cyc", mc, 11);
        next_cycle();
        check("conflict_hit", 32'(bus.p_cache_miss), 32'd0);
        present(16'h1234);
        next_cycle();
        check("evicted_miss", 32'(bus.p_cache_miss), 32'd1);

        // Refill with late ack and 2-cycle gaps between words
        wb = wr_cnt;
        serve(16'h1230, 2, 2, 16'hC000, -1, -1, mc, rc);
        check("gap_req_cyc",  rc, 3);
        check("gap_miss_cyc", mc, 26);
        check("gap_writes",   wr_cnt - wb, 8);
        next_cycle();
        check("gap_hit", 32'(bus.p_cache_miss), 32'd0);

        // Flush during fill: fill completes, then full sweep
        present(16'h2A48);
        wb = wr_cnt;
        serve(16'h2A48, 0, 0, 16'h5000, 4, -1, mc, rc);
        check("flushfill_miss_cyc", mc, 11);
        check("flushfill_writes",   wr_cnt - wb, 8);
        @(negedge clk);
        count_flush(n);
        check("flush_sweep_len", n, 32);
        check("after_flush_miss", 32'(bus.p_cache_miss), 32'd1);

        // Reset at word 4 of the refill
        wb = wr_cnt;
        serve(16'h2A48, 0, 0, 16'hD000, -1, 4, mc, rc);
        #1;
        bus.mem_valid = 1'b1;
        bus.mem_data  = 16'hEEEE;
        #1;
        check("rstfill_writes",  wr_cnt - wb, 4);
        check("rstfill_mem_req", 32'(bus.mem_req),   32'd0);
        check("rstfill_wr_en",   32'(bus.wr_en),     32'd0);
        check("rstfill_state",   32'(bus.state_dbg), 32'(ST_FLUSH));
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        @(negedge clk);
        count_flush(n);
        check("rstfill_sweep_len", n, 32);
        check("partial_line_miss", 32'(bus.p_cache_miss), 32'd1);
        repeat (3) next_cycle();
        check("stray_valid_no_wr", wr_cnt - wb, 4);
        bus.mem_valid = 1'b0;
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
